rtype_program_loader: RTL and testbench

Encoder/loader that assembles LEGv8 R-type ALU instructions (ADD, ADDS, SUB, SUBS, AND, ANDS, ORR, EOR) from field-level requests and writes them sequentially into instruction memory. It is the writer counterpart to the R-type control decode:
- the 3-bit `op_sel` uses the same {opcode[9], opcode[8], opcode[3]} selection the decoder uses;
- encoded words place Rn/Rm/Rd exactly where the decoder extracts SA/SB/DA.

It sits between a test/boot source and the instruction-memory write port.

---
 rtl/rtype_program_loader.sv | 202 ++++++++++++++++++++
 tb/tb_rtype_program_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtype_program_loader.sv
// rtype_program_loader
//
// Assembles LEGv8 R-type ALU instructions (AND, ADD, ORR, ADDS, EOR, SUB,
// ANDS, SUBS) from field-level requests. Each instruction is written to
// instruction memory at sequential word addresses.
//
// The 3-bit op_sel uses the R-type decoder's {opcode[9], opcode[8], opcode[3]}
// selection. Rn, Rm and Rd sit exactly where the decoder extracts SA, SB and DA.
//
// Ports:
//   clock        system clock, rising-edge active
//   reset        asynchronous active-low reset
//   start        begin a load burst (sampled only when idle)
//   base_addr    first write address, latched when start is accepted
//   in_valid     request fields are valid
//   in_ready     loader can accept a request this cycle
//   op_sel       000 AND, 001 ADD, 010 ORR, 011 ADDS,
//                100 EOR, 101 SUB, 110 ANDS, 111 SUBS
//   rd, rn, rm   destination and source register numbers
//   shamt        shift amount field
//   in_last      marks the final request of a burst
//   mem_addr     memory write address
//   mem_data     encoded instruction word
//   mem_write_en write request, held until mem_ack
//   mem_ack      memory accepted the write this cycle
//   busy         high whenever the loader is not idle
//   done         one-cycle pulse at the end of a burst
//   count        instructions written in the current or last burst
module rtype_program_loader #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [5:0]        shamt,
  input  logic              in_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_write_en,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Build an R-type word. The fixed opcode bits are shared by all eight ALU ops.
  function automatic logic [31:0] encode_rtype(
    input logic [2:0] op_sel_v,
    input logic [4:0] rd_v,
    input logic [4:0] rn_v,
    input logic [4:0] rm_v,
    input logic [5:0] shamt_v
  );
    logic [10:0] opcode_v;
    opcode_v = {1'b1, op_sel_v[2], op_sel_v[1], 1'b0, 1'b1, 1'b0, 1'b1,
                op_sel_v[0], 3'b000};
    return {opcode_v, rm_v, shamt_v, rn_v, rd_v};
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         word_r;
  logic                last_r;
  logic [CNT_W-1:0]    count_r;
  logic                in_ready_r;
  logic                mem_write_en_r;
  logic                busy_r;
  logic                done_r;
  logic                accept_fire_s;
  logic                write_fire_s;

  // Handshake qualifiers; each one is only meaningful in its own state.
  always_comb begin
    accept_fire_s = 1'b0;
    write_fire_s  = 1'b0;
    if (state_r == ST_ACCEPT) begin
      accept_fire_s = in_valid;
    end else begin
      accept_fire_s = 1'b0;
    end
    if (state_r == ST_WRITE) begin
      write_fire_s = mem_ack;
    end else begin
      write_fire_s = 1'b0;
    end
  end

  // Next-state logic for the load sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_ACCEPT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_ACCEPT;
        end
      end
      ST_WRITE: begin
        if (mem_ack && last_r) begin
          state_next_s = ST_DONE;
        end else if (mem_ack) begin
          state_next_s = ST_ACCEPT;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Status outputs are registered from the next state. They therefore line up
  // with the state they describe and never depend combinationally on inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready_r     <= 1'b0;
      mem_write_en_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      in_ready_r     <= (state_next_s == ST_ACCEPT);
      mem_write_en_r <= (state_next_s == ST_WRITE);
      busy_r         <= (state_next_s != ST_IDLE);
      done_r         <= (state_next_s == ST_DONE);
    end
  end

  // Datapath: address, count, encoded word and last flag.
  // Once a word is captured, it and the address stay frozen until the write is acked.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r  <= {ADDR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      word_r  <= 32'h0000_0000;
      last_r  <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        addr_r  <= base_addr;
        count_r <= {CNT_W{1'b0}};
      end else if (write_fire_s) begin
        addr_r  <= addr_r + ADDR_W'(3'd4);
        count_r <= count_r + CNT_W'(1'b1);
      end else begin
        addr_r  <= addr_r;
        count_r <= count_r;
      end
      if (accept_fire_s) begin
        word_r <= encode_rtype(op_sel, rd, rn, rm, shamt);
        last_r <= in_last;
      end else begin
        word_r <= word_r;
        last_r <= last_r;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign mem_write_en = mem_write_en_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign mem_addr     = addr_r;
  assign mem_data     = word_r;
  assign count        = count_r;

endmodule

// File: tb/tb_rtype_program_loader.sv
module tb_rtype_program_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [63:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_sel;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [5:0]  shamt;
  logic        in_last;
  logic [63:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_write_en;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic [15:0] count;

  int vec_cnt;
  int err_cnt;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [5:0]  sh;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[11];

  rtype_program_loader #(.ADDR_W(64), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .rd(rd), .rn(rn), .rm(rm), .shamt(shamt), .in_last(in_last),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write_en(mem_write_en),
    .mem_ack(mem_ack), .busy(busy), .done(done), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_burst(input logic [63:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    chk("in_ready_after_start", {63'd0, in_ready}, 64'd1);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Caller sits at a negedge with the loader in ACCEPT.
  task automatic send_req(input logic [2:0] op, input logic [4:0] d, input logic [4:0] n,
                          input logic [4:0] m, input logic [5:0] sh, input logic last,
                          input logic [63:0] exp_addr, input logic [31:0] exp_word,
                          input int delay, input logic [15:0] exp_count);
    chk("req_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; op_sel = op; rd = d; rn = n; rm = m; shamt = sh; in_last = last;
    tick();
    in_valid = 1'b0;
    chk("wr_en", {63'd0, mem_write_en}, 64'd1);
    chk("wr_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("wr_addr", mem_addr, exp_addr);
    chk("wr_data", {32'd0, mem_data}, {32'd0, exp_word});
    for (int k = 0; k < delay; k++) begin
      tick();
      chk("hold_en", {63'd0, mem_write_en}, 64'd1);
      chk("hold_addr", mem_addr, exp_addr);
      chk("hold_data", {32'd0, mem_data}, {32'd0, exp_word});
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("post_ack_wr_en", {63'd0, mem_write_en}, 64'd0);
    chk("post_ack_count", {48'd0, count}, {48'd0, exp_count});
    if (last) begin
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("done_busy", {63'd0, busy}, 64'd1);
      tick();
      chk("done_cleared", {63'd0, done}, 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
      chk("idle_count_hold", {48'd0, count}, {48'd0, exp_count});
    end else begin
      chk("back_to_accept", {63'd0, in_ready}, 64'd1);
      chk("no_done_mid", {63'd0, done}, 64'd0);
    end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    reset = 1'b0; start = 1'b0; base_addr = 64'd0; in_valid = 1'b0;
    op_sel = 3'd0; rd = 5'd0; rn = 5'd0; rm = 5'd0; shamt = 6'd0;
    in_last = 1'b0; mem_ack = 1'b0;

    vecs[0]  = '{3'b001, 5'd3,  5'd1,  5'd2,  6'd0,  32'h8B02_0023};
    vecs[1]  = '{3'b000, 5'd0,  5'd0,  5'd0,  6'd0,  32'h8A00_0000};
    vecs[2]  = '{3'b001, 5'd0,  5'd0,  5'd0,  6'd0,  32'h8B00_0000};
    vecs[3]  = '{3'b010, 5'd0,  5'd0,  5'd0,  6'd0,  32'hAA00_0000};
    vecs[4]  = '{3'b011, 5'd0,  5'd0,  5'd0,  6'd0,  32'hAB00_0000};
    vecs[5]  = '{3'b100, 5'd0,  5'd0,  5'd0,  6'd0,  32'hCA00_0000};
    vecs[6]  = '{3'b101, 5'd0,  5'd0,  5'd0,  6'd0,  32'hCB00_0000};
    vecs[7]  = '{3'b110, 5'd0,  5'd0,  5'd0,  6'd0,  32'hEA00_0000};
    vecs[8]  = '{3'b111, 5'd0,  5'd0,  5'd0,  6'd0,  32'hEB00_0000};
    vecs[9]  = '{3'b100, 5'd31, 5'd30, 5'd29, 6'd63, 32'hCA1D_FFDF};
    vecs[10] = '{3'b010, 5'd5,  5'd6,  5'd7,  6'd5,  32'hAA07_14C5};

    // Reset values.
    repeat (3) tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_wr_en", {63'd0, mem_write_en}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_data", {32'd0, mem_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_count", {48'd0, count}, 64'd0);
    reset = 1'b1;
    tick();

    // Single-instruction bursts from the vector table.
    for (int i = 0; i < 11; i++) begin
      start_burst(64'h1000);
      send_req(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].sh, 1'b1,
               64'h1000, vecs[i].exp_word, 0, 16'd1);
      chk("opcode_field", {53'd0, mem_data[31:21]}, {53'd0, vecs[i].exp_word[31:21]});
    end

    // Two-instruction burst with a three-cycle ack delay on each write.
    start_burst(64'h1000);
    send_req(3'b001, 5'd3, 5'd1, 5'd2, 6'd0, 1'b0, 64'h1000, 32'h8B02_0023, 3, 16'd1);
    send_req(3'b111, 5'd9, 5'd9, 5'd10, 6'd0, 1'b1, 64'h1004, 32'hEB0A_0129, 3, 16'd2);

    // Address wrap, with a spurious ack while waiting in ACCEPT.
    start_burst(64'hFFFF_FFFF_FFFF_FFFC);
    send_req(3'b010, 5'd5, 5'd6, 5'd7, 6'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC,
             32'hAA07_14C5, 0, 16'd1);
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("spurious_ack_addr", mem_addr, 64'd0);
    chk("spurious_ack_count", {48'd0, count}, 64'd1);
    send_req(3'b100, 5'd31, 5'd30, 5'd29, 6'd63, 1'b1, 64'd0, 32'hCA1D_FFDF, 1, 16'd2);

    // Protocol abuse: start and in_valid held during WRITE, then spurious ack in ACCEPT.
    start_burst(64'h2000);
    in_valid = 1'b1; op_sel = 3'b001; rd = 5'd3; rn = 5'd1; rm = 5'd2; shamt = 6'd0;
    in_last = 1'b0;
    tick();
    op_sel = 3'b111; rd = 5'd9; rn = 5'd9; rm = 5'd10; in_last = 1'b1;
    start = 1'b1; base_addr = 64'h9000;
    chk("abuse_data0", {32'd0, mem_data}, 64'h8B02_0023);
    tick();
    start = 1'b0;
    chk("abuse_hold_data", {32'd0, mem_data}, 64'h8B02_0023);
    chk("abuse_hold_addr", mem_addr, 64'h2000);
    chk("abuse_still_wr", {63'd0, mem_write_en}, 64'd1);
    tick();
    chk("abuse_hold_addr2", mem_addr, 64'h2000);
    mem_ack = 1'b1;
    tick();
    chk("abuse_accept", {63'd0, in_ready}, 64'd1);
    chk("abuse_count1", {48'd0, count}, 64'd1);
    tick();
    mem_ack = 1'b0;
    in_valid = 1'b0;
    chk("abuse_second_addr", mem_addr, 64'h2004);
    chk("abuse_second_data", {32'd0, mem_data}, 64'hEB0A_0129);
    chk("abuse_second_wr", {63'd0, mem_write_en}, 64'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("abuse_done", {63'd0, done}, 64'd1);
    chk("abuse_count2", {48'd0, count}, 64'd2);
    tick();
    chk("abuse_idle", {63'd0, busy}, 64'd0);

    // Reset asserted mid-WRITE clears outputs without waiting for a clock.
    start_burst(64'h3000);
    in_valid = 1'b1; op_sel = 3'b001; rd = 5'd3; rn = 5'd1; rm = 5'd2; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_reset_wr", {63'd0, mem_write_en}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_wr_en", {63'd0, mem_write_en}, 64'd0);
    chk("async_addr", mem_addr, 64'd0);
    chk("async_data", {32'd0, mem_data}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    chk("async_count", {48'd0, count}, 64'd0);
    chk("async_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    reset = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_no_ready", {63'd0, in_ready}, 64'd0);
      chk("post_rst_no_wr", {63'd0, mem_write_en}, 64'd0);
    end
    in_valid = 1'b0;
    start_burst(64'h3000);
    send_req(3'b001, 5'd3, 5'd1, 5'd2, 6'd0, 1'b1, 64'h3000, 32'h8B02_0023, 0, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
